// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational MIPS ALU between two requesters: requester 0 is
//   the main datapath and requester 1 is the aux address/branch unit. Each
//   operation passes through three phases. In IDLE the block arbitrates and
//   accepts one request. In EXEC it drives the ALU from registered operands.
//   In RESP it holds the response until the granted requester takes it.
//
//   Configuration macro:
//     ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 wins every tie and
//                             requester 1 can starve. When undefined, ties
//                             are broken round-robin.
//
//   Ports:
//     clk, reset              clock and asynchronous active-high reset
//     req_valid/req_ready     per-requester request handshake (bit i = req i)
//     req_op0/a0/b0           requester 0 op code and operands
//     req_op1/a1/b1           requester 1 op code and operands
//     alu_control/in1/in2     ALU drive, held between operations
//     alu_result              ALU output, sampled during EXEC only
//     rsp_valid/rsp_ready     per-requester response handshake
//     rsp_result/zero/err     shared response payload
//     busy                    high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             gnt_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, err_q;

  logic             any_req;
  logic             win;      // index of the arbitration winner
  logic             accept;
  logic             op_ok;

  assign any_req = |req_valid;
  assign accept  = (state_q == S_IDLE) && any_req;

  // ---------------- arbitration ----------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 always wins when it is valid.
  always_comb begin
    win = ~req_valid[0];
  end
`else
  logic last_q;  // most recently granted requester

  // On a tie the requester that was not served last goes first; a lone
  // requester wins outright.
  always_comb begin
    if (&req_valid) win = ~last_q;
    else            win = ~req_valid[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_q <= 1'b1;
    else if (accept) last_q <= win;
  end
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_ready[gnt_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (state_q != S_IDLE);
    if (state_q == S_IDLE && any_req) req_ready = {win, ~win};
    if (state_q == S_RESP)            rsp_valid = {gnt_q, ~gnt_q};
  end

  // ---------------- datapath ----------------
  always_comb begin
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_ok = 1'b1;
      default:                              op_ok = 1'b0;
    endcase
  end

  // Operand registers double as the ALU drive, so the ALU inputs only
  // change when a new request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      gnt_q <= 1'b0;
    end else if (accept) begin
      op_q  <= win ? req_op1 : req_op0;
      a_q   <= win ? req_a1  : req_a0;
      b_q   <= win ? req_b1  : req_b0;
      gnt_q <= win;
    end
  end

  // The response is captured once at the end of EXEC and then held
  // until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q  <= op_ok ? alu_result : '0;
      zero_q <= (a_q == b_q);
      err_q  <= ~op_ok;
    end
  end

  assign alu_control = op_q;
  assign alu_in1     = a_q;
  assign alu_in2     = b_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk, reset;
  logic [1:0]   req_valid, req_ready;
  logic [2:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]   alu_control;
  logic [W-1:0] alu_in1, alu_in2, alu_result;
  logic [1:0]   rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_err, busy;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; unsupported codes produce junk that must be ignored.
  always_comb begin
    case (alu_control)
      3'b010:  alu_result = alu_in1 + alu_in2;
      3'b110:  alu_result = alu_in1 - alu_in2;
      3'b000:  alu_result = alu_in1 & alu_in2;
      3'b001:  alu_result = alu_in1 | alu_in2;
      3'b111:  alu_result = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: expected response of one operation.
  task automatic ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic e);
    e = 1'b0;
    case (op)
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b111:  r = (a < b) ? 1 : 0;
      default: begin r = 0; e = 1'b1; end
    endcase
  endtask

  // Pending request per requester, with its expected response.
  logic         pend [2];
  logic [2:0]   p_op [2];
  logic [W-1:0] p_a [2], p_b [2], p_res [2];
  logic         p_zero [2], p_err [2];
  int           m_last = 1;   // model's round-robin pointer
  int           last_g;

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                         input logic e);
    pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
    p_res[i] = r; p_zero[i] = z; p_err[i] = e;
  endtask

  task automatic rand_req(input int i);
    logic [2:0] op; logic [W-1:0] a, b, r; logic e;
    op = 3'($urandom);
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    ref_alu(op, a, b, r, e);
    set_req(i, op, a, b, r, (a == b), e);
  endtask

  task automatic drive();
    req_valid = {pend[1], pend[0]};
    req_op0 = p_op[0]; req_a0 = p_a[0]; req_b0 = p_b[0];
    req_op1 = p_op[1]; req_a1 = p_a[1]; req_b1 = p_b[1];
  endtask

  function automatic int exp_winner();
`ifdef ALU_ARB_FIXED_PRIO_EN
    return pend[0] ? 0 : 1;
`else
    if (pend[0] && pend[1]) return (m_last == 1) ? 0 : 1;
    return pend[0] ? 0 : 1;
`endif
  endfunction

  // One full transaction. Entered and left just after a falling edge with
  // the DUT idle; bp = number of cycles the response is back-pressured.
  task automatic txn(input int bp);
    int g; logic [2:0] op; logic [W-1:0] a, b, r; logic z, e;
    logic [1:0] oh;
    drive();
    #1;
    g = exp_winner();
    oh = (g == 1) ? 2'b10 : 2'b01;
    op = p_op[g]; a = p_a[g]; b = p_b[g]; r = p_res[g]; z = p_zero[g]; e = p_err[g];
    chk("idle_req_ready", req_ready, oh);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    m_last = g; last_g = g; pend[g] = 1'b0;
    @(negedge clk);
    drive();
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_req_ready", req_ready, 0);
    chk("exec_alu_control", alu_control, op);
    chk("exec_alu_in1", alu_in1, a);
    chk("exec_alu_in2", alu_in2, b);
    @(negedge clk); #1;
    chk("resp_valid", rsp_valid, oh);
    chk("resp_result", rsp_result, r);
    chk("resp_zero", rsp_zero, z);
    chk("resp_err", rsp_err, e);
    chk("resp_req_ready", req_ready, 0);
    for (int k = 0; k < bp; k++) begin
      rsp_ready = 2'($urandom);
      rsp_ready[g] = 1'b0;        // other requester's ready must be ignored
      @(negedge clk); #1;
      chk("bp_valid", rsp_valid, oh);
      chk("bp_result", rsp_result, r);
      chk("bp_zero", rsp_zero, z);
      chk("bp_err", rsp_err, e);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_alu_in1", alu_in1, a);
    end
    rsp_ready = 2'($urandom);
    rsp_ready[g] = 1'b1;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  typedef struct {
    int         who;
    logic [2:0] op;
    logic [W-1:0] a, b, res;
    logic       z, e;
    int         bp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 3'b010, 32'd5,        32'd7,      32'd12,     1'b0, 1'b0, 0};
    tbl[1] = '{0, 3'b111, 32'd2,        32'd9,      32'd1,      1'b0, 1'b0, 5};
    tbl[2] = '{0, 3'b110, 32'h1234,     32'h1234,   32'd0,      1'b1, 1'b0, 0};
    tbl[3] = '{0, 3'b001, 32'd1,        32'd2,      32'd3,      1'b0, 1'b0, 0};
    tbl[4] = '{1, 3'b100, 32'hAB,       32'hCD,     32'd0,      1'b0, 1'b1, 0};
    tbl[5] = '{1, 3'b000, 32'hFFFF,     32'hFFFF,   32'hFFFF,   1'b1, 1'b0, 2};
    tbl[6] = '{0, 3'b010, 32'hFFFFFFFF, 32'd1,      32'd0,      1'b0, 1'b0, 0};
    tbl[7] = '{1, 3'b111, 32'd9,        32'd2,      32'd0,      1'b0, 1'b0, 1};

    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; p_op[i] = 3'b0; p_a[i] = '0; p_b[i] = '0;
      p_res[i] = '0; p_zero[i] = 1'b0; p_err[i] = 1'b0;
    end
    reset = 1'b1; rsp_ready = 2'b00;
    drive();
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_control", alu_control, 3'b010);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    reset = 1'b0;

    // Tie from reset: req0 first, then req1, then the next tie goes to req0.
    set_req(0, 3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
    set_req(1, 3'b110, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
    txn(0);
    chk("tie1_gnt", last_g, 0);
    txn(0);
    chk("tie1_second_gnt", last_g, 1);
    set_req(0, 3'b001, 32'd4, 32'd8, 32'd12, 1'b0, 1'b0);
    set_req(1, 3'b010, 32'd4, 32'd8, 32'd12, 1'b0, 1'b0);
    txn(0);
    chk("tie2_gnt", last_g, 0);
    txn(1);
    chk("tie2_second_gnt", last_g, 1);
`ifndef ALU_ARB_FIXED_PRIO_EN
    // Requester 1 was served last, so a tie now goes to requester 0, and a
    // tie right after that goes to requester 1.
    set_req(0, 3'b010, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0);
    txn(0);
    set_req(0, 3'b010, 32'd2, 32'd2, 32'd4, 1'b1, 1'b0);
    set_req(1, 3'b110, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0);
    txn(0);
    chk("rr_alternate_gnt", last_g, 1);
    txn(0);
`endif

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].who, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].z, tbl[i].e);
      txn(tbl[i].bp);
    end

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1)) rand_req(i);
      if (!pend[0] && !pend[1]) rand_req($urandom_range(0, 1));
      txn($urandom_range(0, 3));
    end
    while (pend[0] || pend[1]) txn(0);

    // Reset while an operation is in EXEC.
    set_req(0, 3'b010, 32'h1000, 32'h0234, 32'h1234, 1'b0, 1'b0);
    txn(0);
    set_req(0, 3'b001, 32'h5, 32'h6, 32'h7, 1'b0, 1'b0);
    drive();
    @(posedge clk);
    pend[0] = 1'b0;
    @(negedge clk);
    drive(); #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1; #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_result", rsp_result, 0);
    chk("arst_zero", rsp_zero, 0);
    chk("arst_err", rsp_err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_alu_control", alu_control, 3'b010);
    chk("arst_alu_in1", alu_in1, 0);
    chk("arst_alu_in2", alu_in2, 0);
    @(negedge clk); #1;
    chk("arst_hold_valid", rsp_valid, 0);
    reset = 1'b0;
    m_last = 1;
    @(negedge clk); #1;
    chk("arst_no_rsp", rsp_valid, 0);
    set_req(1, 3'b110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
    txn(0);
    set_req(0, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    set_req(1, 3'b000, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0);
    txn(0);
    chk("post_rst_tie_gnt", last_g, 0);
    txn(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single MIPS ALU between two requesters: requester 0 is the main datapath and requester 1 is the auxiliary address/branch unit. The block arbitrates requests, registers the operands, drives the combinational ALU for one cycle, captures the result, and returns it to the granted requester over a valid/ready handshake. It sits between the requesters and the ALU instance and is the ALU's only driver.

## Interface
- Parameters
  - `WIDTH`, 32, operand and result width; must match the ALU.
- Ports
  - `clk` input 1: single clock, rising edge.
  - `reset` input 1: asynchronous, active-high.
  - `req_valid` input 2: per-requester request valid, bit i belongs to requester i.
  - `req_ready` output 2: per-requester accept.
  - `req_op0`, `req_op1` input 3 each: ALU control code.
  - `req_a0`, `req_b0`, `req_a1`, `req_b1` input WIDTH each: operands.
  - `alu_control` output 3: to ALU.
  - `alu_in1`, `alu_in2` output WIDTH: to ALU.
  - `alu_result` input WIDTH: from ALU.
  - `rsp_valid` output 2: per-requester response valid.
  - `rsp_ready` input 2: per-requester response accept.
  - `rsp_result` output WIDTH: response data, shared by both requesters.
  - `rsp_zero` output 1: 1 when the captured operands were equal.
  - `rsp_err` output 1: 1 when the op code was unsupported.
  - `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE
  - `req_ready` = one-hot grant of the arbitration winner when any `req_valid` is set; otherwise 0.
  - On handshake: register op, a, b and the grant index `gnt`; go to EXEC.
- Arbitration (default): round-robin.
  - Pointer `last` holds the most recently granted index; `last` resets to 1, so requester 0 wins the first tie.
  - When both requesters are valid, the one not equal to `last` wins.
  - A lone valid requester always wins.
  - `last` updates on each accept.
- EXEC
  - `alu_control`, `alu_in1` and `alu_in2` are driven from the registers.
  - At the end of the cycle, capture `alu_result` into `rsp_result`.
  - Compute `rsp_zero` internally as (a == b) from the registered operands. It is recomputed per operation and never sticky.
  - Set `rsp_err`; go to RESP.
- Supported op codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
  - Any other code gives `rsp_result`=0 and `rsp_err`=1, and the ALU output is ignored.
- RESP
  - `rsp_valid[gnt]`=1. The other bit stays 0.
  - `rsp_result`, `rsp_zero` and `rsp_err` are held stable until `rsp_ready[gnt]`=1, then go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- Outside EXEC, the ALU inputs hold their last registered values, so there is no toggling.
- Arithmetic is WIDTH-bit wrap-around with no overflow flag. slt is the ALU's unsigned compare, passed through as-is.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0, `alu_control`=010, `alu_in1`=0, `alu_in2`=0, `gnt`=0, `last`=1.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high from N+2.
- Minimum issue interval is 3 cycles when `rsp_ready` is held high.
- `req_ready` is combinational from `req_valid` and state. A requester must hold `req_valid` and its operands stable until accepted.
- Backpressure: RESP persists indefinitely while `rsp_ready`=0, and no new request is accepted.
- Reset asserted in any state: immediately returns to IDLE and clears all outputs. An in-flight operation is dropped with no response.
- A request arriving in the same cycle as a response handshake is not accepted until the next IDLE cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, so requester 0 always wins a tie. `last` is not implemented and requester 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Single add: req0 op=010, a=5, b=7 -> `rsp_valid`=01 two cycles after accept, result=12, zero=0, err=0.
- Simultaneous requests, from reset, both held valid: req0 and=0xF0F0&0xFF00, req1 sub 3-5 -> req0 served first (0xF000), then req1 (0xFFFFFFFE). A following tie is granted to req0. With `ALU_ARB_FIXED_PRIO_EN` defined, req0 wins every tie.
- Backpressure: `rsp_ready`=0 for 5 cycles after a slt 2<9 -> `rsp_valid` and result=1 held stable, `req_ready`=00 throughout.
- Zero flag: sub a=b=0x1234 -> result 0, zero=1. The next op, or 1|2, gives zero=0 (not sticky).
- Bad op 100 on req1 -> result 0, err=1, normal 3-cycle handshake.
- Reset asserted during EXEC -> all outputs return to their reset values asynchronously, no `rsp_valid`, and the next request is accepted normally.
